// File: rtl/multiply_add.sv
// Sequential unsigned shift-add multiplier-accumulator: p = a*b + c.
// One radix-2 iteration per clock, fixed latency of WIDTH RUN cycles plus one DONE cycle.
// Inverse of the restoring divider: quotient*divisor + remainder rebuilds the dividend.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high reset
//   start  - request; accepted only in IDLE or in the DONE cycle
//   a      - multiplicand (latched at start)
//   b      - multiplier (latched at start)
//   c      - addend, zero-extended (latched at start)
//   p      - result a*b+c, updated only on entry to DONE
//   busy   - high while iterating
//   done   - one-cycle pulse when p becomes valid
module multiply_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  // Wide enough to hold WIDTH itself.
  localparam int unsigned CountW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0]  p_q, p_d;
  logic [2*WIDTH-1:0]  acc_sum;

  // Max result is 2^(2W) - 2^W, so the carry out of this adder is always zero.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    p_d      = p_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          acc_d    = {{WIDTH{1'b0}}, c};
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          count_d  = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        // Last iteration: publish the sum including this cycle's conditional add.
        if (count_q == CountW'(WIDTH - 1)) begin
          p_d     = acc_sum;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      p_q      <= p_d;
    end
  end

  assign p    = p_q;
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_multiply_add.sv
// Scoreboard bench for multiply_add: stimulus pushes expected results with their due cycle,
// a negedge monitor pops and compares whenever done pulses.
module tb_multiply_add;

  localparam int unsigned W = 32;

  logic             clock;
  logic             reset;
  logic             start;
  logic [W-1:0]     a, b, c;
  logic [2*W-1:0]   p;
  logic             busy;
  logic             done;

  multiply_add #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .p     (p),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] p;
    int             due;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   busy_run = 0;
  logic [2*W-1:0] last_p = '0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clock) begin
    if (reset) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done=1 with p=0x%0h, expected no done", p);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_p", p, e.p);
        check("done_latency", 64'(cyc), 64'(e.due));
        check("busy_cycles", 64'(busy_run), 64'(W));
        last_p = e.p;
      end
      busy_run = 0;
    end
  end

  // Issue a start that the DUT will accept; start is sampled at the next posedge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic,
                       input logic [2*W-1:0] exp);
    exp_t e;
    start = 1'b1;
    a = ia;
    b = ib;
    c = ic;
    e.p   = exp;
    e.due = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high; an expired bound is a failure.
  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done) return;
      @(negedge clock);
    end
    n_vec++;
    n_miss++;
    $display("FAIL done_timeout: got no done in 200 cycles, expected a done pulse");
  endtask

  initial begin
    logic [W-1:0] dvd, dvs;
    reset = 1'b1;
    start = 1'b1;
    a = '0;
    b = '0;
    c = '0;

    // Reset with start held high: nothing may start.
    repeat (2) begin
      @(negedge clock);
      check("busy_in_reset", 64'(busy), 64'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    check("reset_p", p, '0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clock);

    // Basic product, then p must hold.
    issue(32'd7, 32'd6, 32'd3, 64'd45);
    wait_done();
    repeat (5) @(negedge clock);
    check("p_hold", p, 64'd45);
    check("idle_busy", 64'(busy), 64'd0);

    // Extremes and zero operands (latency must not shrink).
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    wait_done();
    @(negedge clock);
    issue(32'd0, 32'd0, 32'd5, 64'd5);
    wait_done();
    @(negedge clock);

    // Divider round trips.
    issue(32'd14, 32'd7, 32'd2, 64'd100);
    wait_done();
    @(negedge clock);
    issue(32'h1234_5678, 32'h10, 32'hF, 64'h1_2345_678F);
    wait_done();
    @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      dvd = $urandom();
      dvs = $urandom();
      if (i % 4 == 0) dvs = $urandom_range(1, 255);
      if (dvs == 0) dvs = 1;
      issue(dvd / dvs, dvs, dvd % dvs, {{W{1'b0}}, dvd});
      wait_done();
      @(negedge clock);
    end

    // Operand changes and a second start during RUN are ignored.
    issue(32'd100, 32'd200, 32'd7, 64'd20007);
    repeat (4) @(negedge clock);
    a = 32'd1;
    b = 32'd1;
    c = 32'd1;
    repeat (3) @(negedge clock);
    start = 1'b1;
    a = 32'd9;
    b = 32'd9;
    c = 32'd9;
    @(negedge clock);
    start = 1'b0;
    wait_done();

    // Start in the DONE cycle: back-to-back operation.
    issue(32'd9, 32'd9, 32'd0, 64'd81);
    check("busy_after_done_start", 64'(busy), 64'd1);
    wait_done();
    @(negedge clock);

    // Reset at RUN cycle 10 aborts with no done pulse.
    issue(32'd50, 32'd50, 32'd0, 64'd2500);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_p", p, '0);
    repeat (40) @(negedge clock);
    issue(32'd3, 32'd5, 32'd1, 64'd16);
    wait_done();
    repeat (3) @(negedge clock);
    check("final_p_hold", p, 64'd16);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
